// File: rtl/fetch_responder_pkg.sv
// Shared constants and FSM state encoding for fetch_responder.
// The prefetch states exist only when FETCH_PREFETCH_EN is defined.
package fetch_responder_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned PAIR_W = 64;

`ifdef FETCH_PREFETCH_EN
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL_LO,
    ST_FILL_HI,
    ST_PF_LO,
    ST_PF_HI
  } fetch_state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL_LO,
    ST_FILL_HI
  } fetch_state_e;
`endif

endpackage

// File: rtl/fetch_pair_buf.sv
// Two-word fetch pair buffer: valid bit, word-index tag, two data words and a
// combinational hit compare against a caller-supplied tag.
module fetch_pair_buf
  import fetch_responder_pkg::*;
#(
  parameter int unsigned TAG_W = 8
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              clr_i,
  input  logic              wr_lo_i,
  input  logic              wr_hi_i,
  input  logic [TAG_W-1:0]  wr_tag_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              load_i,
  input  logic [TAG_W-1:0]  load_tag_i,
  input  logic [PAIR_W-1:0] load_data_i,
  input  logic [TAG_W-1:0]  match_tag_i,
  output logic              hit_o,
  output logic              valid_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [PAIR_W-1:0] data_o
);

  logic              valid_q;
  logic [TAG_W-1:0]  tag_q;
  logic [DATA_W-1:0] data_lo_q;
  logic [DATA_W-1:0] data_hi_q;

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      valid_q   <= 1'b0;
      tag_q     <= '0;
      data_lo_q <= '0;
      data_hi_q <= '0;
    end else if (load_i) begin
      valid_q   <= 1'b1;
      tag_q     <= load_tag_i;
      data_lo_q <= load_data_i[DATA_W-1:0];
      data_hi_q <= load_data_i[PAIR_W-1:DATA_W];
    end else begin
      if (clr_i) valid_q <= 1'b0;
      if (wr_lo_i) data_lo_q <= wr_data_i;
      // The pair only becomes visible once the upper word has landed.
      if (wr_hi_i) begin
        data_hi_q <= wr_data_i;
        tag_q     <= wr_tag_i;
        valid_q   <= 1'b1;
      end
    end
  end

  assign hit_o   = valid_q && (tag_q == match_tag_i);
  assign valid_o = valid_q;
  assign tag_o   = tag_q;
  assign data_o  = {data_hi_q, data_lo_q};

endmodule

// File: rtl/fetch_responder.sv
// Fetch pair responder: serves word W and W+1 from a pair buffer, filling it
// from backing memory on a miss. Optional prefetch buffer: FETCH_PREFETCH_EN.
module fetch_responder
  import fetch_responder_pkg::*;
#(
  parameter int unsigned ADDR_W = 10
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic [ADDR_W-1:0] iaddr_i,
  output logic [PAIR_W-1:0] idata_o,
  output logic              stall_o,
  output logic              mem_req_o,
  output logic [ADDR_W-3:0] mem_addr_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned IDX_W = ADDR_W - 2;

  fetch_state_e     state_q, state_d;
  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] fill_idx_q, fill_idx_d;
  logic             hit;
  logic             clr, wr_lo, wr_hi;
  logic             load;
  logic [IDX_W-1:0] pf_tag;
  logic [PAIR_W-1:0] pf_data;
  logic             pair_valid_unused;
  logic [IDX_W-1:0] pair_tag_unused;
  logic             iaddr_lsb_unused;

  assign req_idx          = iaddr_i[ADDR_W-1:2];
  assign iaddr_lsb_unused = ^iaddr_i[1:0];
  assign stall_o          = !hit;

  fetch_pair_buf #(.TAG_W(IDX_W)) u_pair (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clr_i       (clr),
    .wr_lo_i     (wr_lo),
    .wr_hi_i     (wr_hi),
    .wr_tag_i    (fill_idx_q),
    .wr_data_i   (mem_rdata_i),
    .load_i      (load),
    .load_tag_i  (pf_tag),
    .load_data_i (pf_data),
    .match_tag_i (req_idx),
    .hit_o       (hit),
    .valid_o     (pair_valid_unused),
    .tag_o       (pair_tag_unused),
    .data_o      (idata_o)
  );

`ifdef FETCH_PREFETCH_EN
  logic pf_clr, pf_wr_lo, pf_wr_hi;
  logic pf_valid, pf_next_hit;

  fetch_pair_buf #(.TAG_W(IDX_W)) u_pf (
    .clock_i     (clock_i),
    .reset_i     (reset_i),
    .clr_i       (pf_clr),
    .wr_lo_i     (pf_wr_lo),
    .wr_hi_i     (pf_wr_hi),
    .wr_tag_i    (fill_idx_q),
    .wr_data_i   (mem_rdata_i),
    .load_i      (1'b0),
    .load_tag_i  ('0),
    .load_data_i ('0),
    .match_tag_i (req_idx + IDX_W'(2)),
    .hit_o       (pf_next_hit),
    .valid_o     (pf_valid),
    .tag_o       (pf_tag),
    .data_o      (pf_data)
  );
`else
  assign pf_tag  = '0;
  assign pf_data = '0;
`endif

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_IDLE;
      fill_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      fill_idx_q <= fill_idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fill_idx_d = fill_idx_q;
    clr        = 1'b0;
    wr_lo      = 1'b0;
    wr_hi      = 1'b0;
    load       = 1'b0;
    mem_req_o  = 1'b0;
    mem_addr_o = '0;
`ifdef FETCH_PREFETCH_EN
    pf_clr     = 1'b0;
    pf_wr_lo   = 1'b0;
    pf_wr_hi   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef FETCH_PREFETCH_EN
        // Hit: run ahead to W+2. Miss on the prefetched pair: copy it over
        // in one stall cycle. Otherwise fall back to a demand fill.
        if (hit) begin
          if (!pf_next_hit) begin
            state_d    = ST_PF_LO;
            fill_idx_d = req_idx + IDX_W'(2);
            pf_clr     = 1'b1;
          end
        end else if (pf_valid && (pf_tag == req_idx)) begin
          load = 1'b1;
        end else begin
          state_d    = ST_FILL_LO;
          fill_idx_d = req_idx;
          clr        = 1'b1;
        end
`else
        if (!hit) begin
          state_d    = ST_FILL_LO;
          fill_idx_d = req_idx;
          clr        = 1'b1;
        end
`endif
      end
      ST_FILL_LO: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fill_idx_q;
        if (mem_ack_i) begin
          wr_lo   = 1'b1;
          state_d = ST_FILL_HI;
        end
      end
      ST_FILL_HI: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fill_idx_q + IDX_W'(1);
        if (mem_ack_i) begin
          wr_hi   = 1'b1;
          state_d = ST_IDLE;
        end
      end
`ifdef FETCH_PREFETCH_EN
      ST_PF_LO: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fill_idx_q;
        if (mem_ack_i) begin
          pf_wr_lo = 1'b1;
          state_d  = ST_PF_HI;
        end
      end
      ST_PF_HI: begin
        mem_req_o  = 1'b1;
        mem_addr_o = fill_idx_q + IDX_W'(1);
        if (mem_ack_i) begin
          pf_wr_hi = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

endmodule
